// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - UART byte stream, response and register-file bus bundle
interface uart_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       reg_wr_en;
  logic [3:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       cmd_err;
  logic       rx_drop;

  // Controller side: consumes bytes, drives responses and register accesses
  modport master (
    input  rx_valid, rx_data, tx_busy, reg_rd_data,
    output tx_start, tx_data, reg_wr_en, reg_addr, reg_wr_data, cmd_err, rx_drop
  );

  // Environment side: UART receiver/transmitter and register file
  modport slave (
    output rx_valid, rx_data, tx_busy, reg_rd_data,
    input  tx_start, tx_data, reg_wr_en, reg_addr, reg_wr_data, cmd_err, rx_drop
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command parser driving a 16-entry register file
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst,
  uart_cmd_ctrl_if.master bus
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ERR  = 8'h45;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam int         CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, DO_READ, DO_WRITE, SEND, TX_HOLD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] to_cnt, to_cnt_n;
  logic          op_write, op_write_n;
  logic [7:0]    tx_data_q, tx_data_n;
  logic [3:0]    addr_q, addr_n;
  logic [7:0]    wdata_q, wdata_n;
  logic          tx_start_c, reg_wr_en_c, cmd_err_c, rx_drop_c;

  // State and datapath registers; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      op_write  <= 1'b0;
      tx_data_q <= 8'h00;
      addr_q    <= 4'h0;
      wdata_q   <= 8'h00;
    end else begin
      state     <= state_n;
      to_cnt    <= to_cnt_n;
      op_write  <= op_write_n;
      tx_data_q <= tx_data_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
    end
  end

  // Frame parsing, inter-byte timeout and the one-cycle strobes
  always_comb begin
    state_n     = state;
    to_cnt_n    = to_cnt;
    op_write_n  = op_write;
    tx_data_n   = tx_data_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    tx_start_c  = 1'b0;
    reg_wr_en_c = 1'b0;
    cmd_err_c   = 1'b0;
    rx_drop_c   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
            op_write_n = (bus.rx_data == OP_WRITE);
            to_cnt_n   = '0;
            state_n    = GET_ADDR;
          end else begin
            tx_data_n = RSP_ERR;
            cmd_err_c = 1'b1;
            state_n   = SEND;
          end
        end
      end

      GET_ADDR: begin
        if (bus.rx_valid) begin
          to_cnt_n = '0;
          if (bus.rx_data[7:4] != 4'h0) begin
            tx_data_n = RSP_ERR;
            cmd_err_c = 1'b1;
            state_n   = SEND;
          end else begin
            addr_n  = bus.rx_data[3:0];
            state_n = op_write ? GET_DATA : DO_READ;
          end
        end else if (to_cnt == TO_LAST) begin
          to_cnt_n  = '0;
          cmd_err_c = 1'b1;
          state_n   = IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end

      GET_DATA: begin
        if (bus.rx_valid) begin
          to_cnt_n = '0;
          wdata_n  = bus.rx_data;
          state_n  = DO_WRITE;
        end else if (to_cnt == TO_LAST) begin
          to_cnt_n  = '0;
          cmd_err_c = 1'b1;
          state_n   = IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end

      DO_READ: begin
        rx_drop_c = bus.rx_valid;
        tx_data_n = bus.reg_rd_data;
        state_n   = SEND;
      end

      DO_WRITE: begin
        rx_drop_c   = bus.rx_valid;
        reg_wr_en_c = 1'b1;
        tx_data_n   = RSP_OK;
        state_n     = SEND;
      end

      SEND: begin
        rx_drop_c = bus.rx_valid;
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          state_n    = TX_HOLD;
        end
      end

      TX_HOLD: begin
        rx_drop_c = bus.rx_valid;
        state_n   = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Strobes are decoded from the current state, so mask them while reset is held
    if (rst) begin
      tx_start_c  = 1'b0;
      reg_wr_en_c = 1'b0;
      cmd_err_c   = 1'b0;
      rx_drop_c   = 1'b0;
    end
  end

  assign bus.tx_start    = tx_start_c;
  assign bus.tx_data     = tx_data_q;
  assign bus.reg_wr_en   = reg_wr_en_c;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.cmd_err     = cmd_err_c;
  assign bus.rx_drop     = rx_drop_c;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

  logic clk;
  logic rst;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model, reloaded with a known pattern on reset
  logic [7:0] rf [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h10 + 8'(i);
    end else if (bus.reg_wr_en) begin
      rf[bus.reg_addr] <= bus.reg_wr_data;
    end
  end
  assign bus.reg_rd_data = rf[bus.reg_addr];

  // Event monitor sampled on the falling edge
  int         cyc, n_tx, n_wr, n_err, n_drop, tx_cyc, wr_cyc;
  logic [7:0] last_tx, last_wdata;
  logic [3:0] last_waddr;
  initial begin
    cyc = 0; n_tx = 0; n_wr = 0; n_err = 0; n_drop = 0; tx_cyc = 0; wr_cyc = 0;
    last_tx = 8'h00; last_wdata = 8'h00; last_waddr = 4'h0;
  end
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_start) begin n_tx <= n_tx + 1; last_tx <= bus.tx_data; tx_cyc <= cyc; end
    if (bus.reg_wr_en) begin
      n_wr <= n_wr + 1; last_waddr <= bus.reg_addr; last_wdata <= bus.reg_wr_data; wr_cyc <= cyc;
    end
    if (bus.cmd_err) n_err <= n_err + 1;
    if (bus.rx_drop) n_drop <= n_drop + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_tx, b_wr, b_err, b_drop;
  task automatic snap();
    @(negedge clk);
    b_tx = n_tx; b_wr = n_wr; b_err = n_err; b_drop = n_drop;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    rst          = 1'b1;

    // Reset with a byte presented: must be ignored
    idle(2);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h41;
    @(negedge clk);
    check("rst_cmd_err", bus.cmd_err, 1'b0);
    check("rst_rx_drop", bus.rx_drop, 1'b0);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_reg_wr_en", bus.reg_wr_en, 1'b0);
    check("rst_reg_addr", bus.reg_addr, 4'h0);
    check("rst_reg_wr_data", bus.reg_wr_data, 8'h00);
    check("rst_no_err", n_err, 0);

    // Write frame W,3,A5
    snap();
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
    idle(10);
    check("wr_count", n_wr - b_wr, 1);
    check("wr_addr", last_waddr, 4'h3);
    check("wr_data", last_wdata, 8'hA5);
    check("wr_tx_count", n_tx - b_tx, 1);
    check("wr_tx_data", last_tx, 8'h4B);
    check("wr_to_tx_lat", tx_cyc - wr_cyc, 1);
    check("wr_hold_addr", bus.reg_addr, 4'h3);
    check("wr_hold_wdata", bus.reg_wr_data, 8'hA5);

    // Read back R,3
    snap();
    send_byte(8'h52); send_byte(8'h03);
    idle(10);
    check("rd_tx_count", n_tx - b_tx, 1);
    check("rd_tx_data", last_tx, 8'hA5);
    check("rd_no_write", n_wr - b_wr, 0);

    // Unknown opcode
    snap();
    send_byte(8'h41);
    idle(10);
    check("badop_err", n_err - b_err, 1);
    check("badop_tx_count", n_tx - b_tx, 1);
    check("badop_tx_data", last_tx, 8'h45);

    // Address out of range
    snap();
    send_byte(8'h57); send_byte(8'h13);
    idle(10);
    check("badaddr_err", n_err - b_err, 1);
    check("badaddr_tx_data", last_tx, 8'h45);
    check("badaddr_no_write", n_wr - b_wr, 0);
    check("badaddr_keep_addr", bus.reg_addr, 4'h3);

    // Timeout after lone W: error on the 16th idle cycle
    snap();
    send_byte(8'h57);
    repeat (15) @(negedge clk);
    check("to_early", n_err - b_err, 0);
    @(negedge clk);
    check("to_pulse", bus.cmd_err, 1'b1);
    idle(5);
    check("to_err_count", n_err - b_err, 1);
    check("to_no_tx", n_tx - b_tx, 0);
    check("to_no_write", n_wr - b_wr, 0);
    snap();
    send_byte(8'h52); send_byte(8'h00);
    idle(10);
    check("to_next_tx", n_tx - b_tx, 1);
    check("to_next_data", last_tx, 8'h10);

    // Transmitter busy: response held, extra byte dropped
    snap();
    bus.tx_busy = 1'b1;
    send_byte(8'h52); send_byte(8'h05);
    send_byte(8'h52);
    idle(5);
    check("busy_drop", n_drop - b_drop, 1);
    check("busy_no_tx", n_tx - b_tx, 0);
    bus.tx_busy = 1'b0;
    idle(10);
    check("busy_tx_count", n_tx - b_tx, 1);
    check("busy_tx_data", last_tx, 8'h15);
    check("busy_no_err", n_err - b_err, 0);

    // Back-to-back reads right after TX_HOLD
    snap();
    send_byte(8'h52); send_byte(8'h03);
    idle(2);
    send_byte(8'h52); send_byte(8'h04);
    idle(10);
    check("b2b_tx_count", n_tx - b_tx, 2);
    check("b2b_tx_data", last_tx, 8'h14);

    // Reset mid-frame
    snap();
    send_byte(8'h57); send_byte(8'h05);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wr_en", bus.reg_wr_en, 1'b0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_addr", bus.reg_addr, 4'h0);
    check("midrst_wdata", bus.reg_wr_data, 8'h00);
    check("midrst_tx_data", bus.tx_data, 8'h00);
    idle(10);
    check("midrst_no_write", n_wr - b_wr, 0);
    check("midrst_no_tx", n_tx - b_tx, 0);
    check("midrst_no_err", n_err - b_err, 0);
    snap();
    send_byte(8'h57); send_byte(8'h05); send_byte(8'h3C);
    idle(10);
    check("postrst_wr", n_wr - b_wr, 1);
    check("postrst_addr", last_waddr, 4'h5);
    check("postrst_data", last_wdata, 8'h3C);
    check("postrst_tx", last_tx, 8'h4B);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, the maximum idle cycles allowed between bytes of one frame.
REQ-002 The block SHALL have port clk  input  1  the clock; all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset: rst, synchronous, active-high.
REQ-004 The block SHALL have port rx_valid  input  1  one-cycle pulse, received byte on rx_data.
REQ-005 The block SHALL have port rx_data  input  8  received UART byte.
REQ-006 The block SHALL have port tx_busy  input  1  transmitter busy; high no later than the cycle after tx_start.
REQ-007 The block SHALL have port tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-008 The block SHALL have port tx_data  output  8  response byte, registered, stable from tx_start until the next response.
REQ-009 The block SHALL have port reg_wr_en  output  1  one-cycle register-file write strobe.
REQ-010 The block SHALL have port reg_addr  output  4  register-file address, registered.
REQ-011 The block SHALL have port reg_wr_data  output  8  register-file write data, registered.
REQ-012 The block SHALL have port reg_rd_data  input  8  register-file read data, combinational from reg_addr.
REQ-013 The block SHALL have port cmd_err  output  1  one-cycle pulse per malformed or timed-out frame.
REQ-014 The block SHALL have port rx_drop  output  1  one-cycle pulse per byte discarded while busy.

Function
REQ-015 Frame formats SHALL be: write = 0x57 ('W'), addr, data; read = 0x52 ('R'), addr.
REQ-016 States SHALL be IDLE, GET_ADDR, GET_DATA, DO_READ, DO_WRITE, SEND, TX_HOLD.
REQ-017 IDLE, rx_valid with 0x57 or 0x52: latch opcode, go GET_ADDR; any other byte: tx_data<=0x45 ('E'), cmd_err pulse, go SEND.
REQ-018 GET_ADDR, rx_valid: rx_data[7:4]!=0 -> tx_data<=0x45, cmd_err pulse, go SEND; else reg_addr<=rx_data[3:0], go GET_DATA (W) or DO_READ (R).
REQ-019 GET_DATA, rx_valid: reg_wr_data<=rx_data, go DO_WRITE.
REQ-020 DO_WRITE: reg_wr_en high exactly this one cycle, tx_data<=0x4B ('K'), go SEND.
REQ-021 DO_READ: tx_data<=reg_rd_data (reg_addr already stable), go SEND; no write strobe.
REQ-022 SEND: when tx_busy=0, tx_start pulses one cycle, go TX_HOLD; while tx_busy=1 remain in SEND, tx_start low.
REQ-023 TX_HOLD: exactly one cycle, then IDLE (covers transmitter busy-rise latency).
REQ-024 Timeout counter SHALL clear on entering GET_ADDR/GET_DATA and on every accepted byte; after TIMEOUT_CYCLES consecutive cycles without rx_valid in GET_ADDR or GET_DATA: cmd_err pulse, go IDLE, no response, no write.
REQ-025 rx_valid in DO_READ, DO_WRITE, SEND or TX_HOLD: byte discarded, rx_drop pulse same cycle, state unaffected.
REQ-026 Write-to-read latency: 'W' data byte accepted in cycle N -> reg_wr_en in cycle N+1 -> tx_start no earlier than N+2.
REQ-027 reg_addr and reg_wr_data SHALL hold their last values outside frames; only the parser updates them.
REQ-028 Back-to-back frames SHALL be accepted from IDLE with no extra gap beyond TX_HOLD.

Reset
REQ-029 rst high SHALL force state IDLE, timeout counter 0, tx_start 0, tx_data 0x00, reg_wr_en 0, reg_addr 0, reg_wr_data 0x00, cmd_err 0, rx_drop 0.
REQ-030 rst mid-frame SHALL abort with no write, no tx_start, no cmd_err; rx_valid while rst high SHALL be ignored.

Verification
REQ-031 Bytes 0x57,0x03,0xA5, tx_busy=0 -> one reg_wr_en with reg_addr=3, reg_wr_data=0xA5; tx_start with tx_data=0x4B.
REQ-032 After REQ-031, bytes 0x52,0x03 with reg file model -> tx_start with tx_data=0xA5, reg_wr_en never high.
REQ-033 Bytes 0x41 -> cmd_err pulse, tx_data=0x45; bytes 0x57,0x13 -> cmd_err, tx_data=0x45, no write.
REQ-034 TIMEOUT_CYCLES=16, byte 0x57 then 16 idle cycles -> cmd_err, IDLE, no tx_start; next 0x52,0x00 handled normally.
REQ-035 tx_busy held 1 during response, 0x52 sent meanwhile -> rx_drop pulse, tx_start only after tx_busy falls, one response only.
REQ-036 rst asserted after 0x57,0x05 -> no reg_wr_en, all outputs at reset values; subsequent full write frame succeeds.
